// File: rtl/fp32_to_bf16_narrow.sv
// ============================================================================
// Module   : fp32_to_bf16_narrow
// Purpose  : Two-stage valid/ready pipeline narrowing binary32 to bfloat16
//            (round-to-nearest-even) with sticky exception flags.
//            Optional macro BF16_FTZ_EN flushes denormal inputs to signed zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp32_to_bf16_narrow #(
    parameter int          PIPE_OUT  = 1,
    parameter logic [15:0] CANON_NAN = 16'h7FC0
) (
    input  logic        clock,
    input  logic        nreset,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    input  logic        flag_clear,
    output logic        flag_inexact,
    output logic        flag_overflow,
    output logic        flag_nan,
    output logic        flag_underflow
);

    localparam logic [7:0] EXP_MAX = 8'hFF;

    logic        adv1;
    logic        adv2;
    logic        in_fire;
    logic        out_fire;

    logic        init_q, init_d;

    logic        s1_valid_q, s1_valid_d;
    logic [15:0] s1_upper_q, s1_upper_d;
    logic        s1_inc_q,   s1_inc_d;
    logic        s1_rnd_q,   s1_rnd_d;
    logic        s1_nan_q,   s1_nan_d;
    logic        s1_pass_q,  s1_pass_d;

    logic [15:0] res_data;
    logic [2:0]  res_flags;     // {nan, overflow, inexact}
    logic [2:0]  out_flags;
    logic [2:0]  flags_q, flags_d;

`ifdef BF16_FTZ_EN
    logic        s1_dnm_q, s1_dnm_d;
    logic        res_unf;
    logic        out_unf;
    logic        unf_q, unf_d;
`endif

    // in_ready stays low until the first clock after reset release
    assign init_d   = 1'b1;
    assign adv1     = !s1_valid_q | adv2;
    assign in_ready = init_q & adv1;
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        s1_valid_d = adv1 ? in_fire : s1_valid_q;
        s1_upper_d = s1_upper_q;
        s1_inc_d   = s1_inc_q;
        s1_rnd_d   = s1_rnd_q;
        s1_nan_d   = s1_nan_q;
        s1_pass_d  = s1_pass_q;
`ifdef BF16_FTZ_EN
        s1_dnm_d   = s1_dnm_q;
`endif
        if (in_fire) begin
            s1_upper_d = in_data[31:16];
            s1_inc_d   = in_data[15] & ((|in_data[14:0]) | in_data[16]);
            s1_rnd_d   = in_data[15] | (|in_data[14:0]);
            s1_nan_d   = (in_data[30:23] == EXP_MAX) && (in_data[22:0] != 23'd0);
            s1_pass_d  = ((in_data[30:23] == EXP_MAX) && (in_data[22:0] == 23'd0)) ||
                         (in_data[30:0] == 31'd0);
`ifdef BF16_FTZ_EN
            s1_dnm_d   = (in_data[30:23] == 8'd0) && (in_data[22:0] != 23'd0);
`endif
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            init_q     <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_upper_q <= 16'd0;
            s1_inc_q   <= 1'b0;
            s1_rnd_q   <= 1'b0;
            s1_nan_q   <= 1'b0;
            s1_pass_q  <= 1'b0;
        end else begin
            init_q     <= init_d;
            s1_valid_q <= s1_valid_d;
            s1_upper_q <= s1_upper_d;
            s1_inc_q   <= s1_inc_d;
            s1_rnd_q   <= s1_rnd_d;
            s1_nan_q   <= s1_nan_d;
            s1_pass_q  <= s1_pass_d;
        end
    end

    // Rounding carry out of the mantissa lands in the exponent; an all-ones
    // exponent after the add is therefore exactly the overflow-to-Inf case.
    always_comb begin
        res_data  = s1_upper_q;
        res_flags = 3'b000;
`ifdef BF16_FTZ_EN
        res_unf   = 1'b0;
`endif
        if (s1_nan_q) begin
            res_data     = {s1_upper_q[15], CANON_NAN[14:0]};
            res_flags[2] = 1'b1;
        end else if (s1_pass_q) begin
            res_data = s1_upper_q;
`ifdef BF16_FTZ_EN
        end else if (s1_dnm_q) begin
            res_data     = {s1_upper_q[15], 15'd0};
            res_flags[0] = 1'b1;
            res_unf      = 1'b1;
`endif
        end else begin
            res_data     = s1_upper_q + {15'd0, s1_inc_q};
            res_flags[0] = s1_rnd_q;
            res_flags[1] = (res_data[14:7] == EXP_MAX);
        end
    end

    generate
        if (PIPE_OUT != 0) begin : g_pipe_out
            logic        s2_valid_q, s2_valid_d;
            logic [15:0] s2_data_q,  s2_data_d;
            logic [2:0]  s2_flags_q, s2_flags_d;
`ifdef BF16_FTZ_EN
            logic        s2_unf_q,   s2_unf_d;
`endif

            assign adv2 = !s2_valid_q | out_ready;

            always_comb begin
                s2_valid_d = adv2 ? s1_valid_q : s2_valid_q;
                s2_data_d  = s2_data_q;
                s2_flags_d = s2_flags_q;
`ifdef BF16_FTZ_EN
                s2_unf_d   = s2_unf_q;
`endif
                if (adv2 && s1_valid_q) begin
                    s2_data_d  = res_data;
                    s2_flags_d = res_flags;
`ifdef BF16_FTZ_EN
                    s2_unf_d   = res_unf;
`endif
                end
            end

            always_ff @(posedge clock or negedge nreset) begin
                if (!nreset) begin
                    s2_valid_q <= 1'b0;
                    s2_data_q  <= 16'd0;
                    s2_flags_q <= 3'b000;
`ifdef BF16_FTZ_EN
                    s2_unf_q   <= 1'b0;
`endif
                end else begin
                    s2_valid_q <= s2_valid_d;
                    s2_data_q  <= s2_data_d;
                    s2_flags_q <= s2_flags_d;
`ifdef BF16_FTZ_EN
                    s2_unf_q   <= s2_unf_d;
`endif
                end
            end

            assign out_valid = s2_valid_q;
            assign out_data  = s2_data_q;
            assign out_flags = s2_flags_q;
`ifdef BF16_FTZ_EN
            assign out_unf   = s2_unf_q;
`endif
        end else begin : g_comb_out
            assign adv2      = out_ready;
            assign out_valid = s1_valid_q;
            assign out_data  = res_data;
            assign out_flags = res_flags;
`ifdef BF16_FTZ_EN
            assign out_unf   = res_unf;
`endif
        end
    endgenerate

    // Set wins over a coincident clear
    assign flags_d = (flags_q & ~{3{flag_clear}}) | (out_fire ? out_flags : 3'b000);

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            flags_q <= 3'b000;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign flag_nan      = flags_q[2];
    assign flag_overflow = flags_q[1];
    assign flag_inexact  = flags_q[0];

`ifdef BF16_FTZ_EN
    assign unf_d = (unf_q & ~flag_clear) | (out_fire & out_unf);

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            unf_q <= 1'b0;
        end else begin
            unf_q <= unf_d;
        end
    end

    assign flag_underflow = unf_q;
`else
    assign flag_underflow = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fp32_to_bf16_narrow.sv
// ============================================================================
// Module   : tb_fp32_to_bf16_narrow
// Purpose  : Self-checking bench for fp32_to_bf16_narrow (default PIPE_OUT=1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp32_to_bf16_narrow;

    logic        clock = 1'b0;
    logic        nreset = 1'b0;
    logic [31:0] in_data = 32'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        flag_clear = 1'b0;
    logic        flag_inexact;
    logic        flag_overflow;
    logic        flag_nan;
    logic        flag_underflow;

    fp32_to_bf16_narrow dut (
        .clock          (clock),
        .nreset         (nreset),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .flag_clear     (flag_clear),
        .flag_inexact   (flag_inexact),
        .flag_overflow  (flag_overflow),
        .flag_nan       (flag_nan),
        .flag_underflow (flag_underflow)
    );

    always #5 clock = ~clock;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [19:0] expq[$];           // {flags, data} of accepted, not yet output items
    logic [16:0] expdq[$];          // expected data per observed output (bit16 = spurious)
    logic [16:0] obsq[$];
    logic [3:0]  model_flags = 4'd0; // {nan, overflow, inexact, underflow}

    logic        smp_in_ready, smp_out_valid, smp_in_fire, smp_out_fire;
    logic [15:0] smp_out_data;

    function automatic logic [3:0] dut_flags();
        return {flag_nan, flag_overflow, flag_inexact, flag_underflow};
    endfunction

    // Reference: RNE by comparing the discarded half-word against one half ulp
    function automatic logic [19:0] ref_conv(input logic [31:0] x);
        logic [15:0] hi, r;
        int          rem;
        logic        ovf, inx;
        hi  = x[31:16];
        rem = int'(x[15:0]);
        if (x[30:23] == 8'hFF && x[22:0] != 23'd0) return {4'b1000, x[31], 15'h7FC0};
        if (x[30:23] == 8'hFF) return {4'b0000, hi};
`ifdef BF16_FTZ_EN
        if (x[30:23] == 8'h00 && x[22:0] != 23'd0) return {4'b0011, x[31], 15'd0};
`endif
        r = hi;
        if (rem > 32768 || (rem == 32768 && hi[0])) r = hi + 16'd1;
        inx = (rem != 0);
        ovf = (r[14:0] == 15'h7F80);
        return {1'b0, ovf, inx, 1'b0, r};
    endfunction

    task automatic step(input logic v, input logic [31:0] d, input logic ordy, input logic clr);
        logic [3:0]  nf;
        logic [19:0] e;
        nf = 4'd0;
        in_valid = v; in_data = d; out_ready = ordy; flag_clear = clr;
        @(negedge clock);
        smp_in_ready  = in_ready;
        smp_out_valid = out_valid;
        smp_out_data  = out_data;
        smp_in_fire   = in_valid & in_ready;
        smp_out_fire  = out_valid & out_ready;
        if (smp_out_fire) begin
            obsq.push_back({1'b0, out_data});
            if (expq.size() > 0) begin
                e = expq.pop_front();
                expdq.push_back({1'b0, e[15:0]});
                nf = e[19:16];
            end else begin
                expdq.push_back(17'h10000);
            end
        end
        if (smp_in_fire) expq.push_back(ref_conv(in_data));
        @(posedge clock);
        model_flags = (model_flags & ~{4{clr}}) | nf;
        #1;
    endtask

    task automatic flush();
        for (int i = 0; i < 40 && expq.size() > 0; i++) step(1'b0, 32'd0, 1'b1, 1'b0);
        step(1'b0, 32'd0, 1'b1, 1'b0);
        step(1'b0, 32'd0, 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clock);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out_data !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_out: valid=%b data=%h, want 0/0000", out_valid, out_data);
        end
        n_cmp++;
        if (dut_flags() !== 4'd0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: flags=%b in_ready=%b, want 0000/0", dut_flags(), in_ready);
        end
        nreset = 1'b1;
        @(posedge clock);
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: in_ready=%b, want 1", in_ready);
        end
    endtask

    task automatic test_latency();
        step(1'b1, 32'h3F800000, 1'b1, 1'b0);
        n_cmp++;
        if (smp_in_fire !== 1'b1) begin
            n_fail++;
            $display("FAIL lat_accept: fire=%b, want 1", smp_in_fire);
        end
        step(1'b0, 32'd0, 1'b1, 1'b0);
        n_cmp++;
        if (smp_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL lat_early: out_valid=%b, want 0", smp_out_valid);
        end
        step(1'b0, 32'd0, 1'b1, 1'b0);
        n_cmp++;
        if (smp_out_valid !== 1'b1 || smp_out_data !== 16'h3F80) begin
            n_fail++;
            $display("FAIL lat_out: valid=%b data=%h, want 1/3F80", smp_out_valid, smp_out_data);
        end
        n_cmp++;
        if (dut_flags() !== 4'd0) begin
            n_fail++;
            $display("FAIL lat_flags: flags=%b, want 0000", dut_flags());
        end
        flush();
        expdq.delete(); obsq.delete();
    endtask

    task automatic test_directed();
        logic [31:0] vin[10];
        logic [15:0] vout[10];
        logic [3:0]  vfl[10];
        vin  = '{32'h3F800000, 32'h3F808000, 32'h3F818000, 32'h3F808001, 32'h7F7FFFFF,
                 32'hFF800000, 32'h7FA00001, 32'hFFC00000, 32'h00008000, 32'h7F7F0000};
        vout = '{16'h3F80, 16'h3F80, 16'h3F82, 16'h3F81, 16'h7F80,
                 16'hFF80, 16'h7FC0, 16'hFFC0, 16'h0000, 16'h7F7F};
`ifdef BF16_FTZ_EN
        vfl  = '{4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0110,
                 4'b0000, 4'b1000, 4'b1000, 4'b0011, 4'b0000};
`else
        vfl  = '{4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0110,
                 4'b0000, 4'b1000, 4'b1000, 4'b0010, 4'b0000};
`endif
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 32'd0, 1'b1, 1'b1);
            step(1'b1, vin[i], 1'b1, 1'b0);
            flush();
            n_cmp++;
            if (obsq.size() != 1 || obsq[0] !== {1'b0, vout[i]}) begin
                n_fail++;
                $display("FAIL dir_data[%h]: got %0d items first %h, want 1 item %h",
                         vin[i], obsq.size(), (obsq.size() > 0) ? obsq[0] : 17'h0, vout[i]);
            end
            n_cmp++;
            if (dut_flags() !== vfl[i]) begin
                n_fail++;
                $display("FAIL dir_flags[%h]: got %b, want %b", vin[i], dut_flags(), vfl[i]);
            end
            expdq.delete(); obsq.delete();
        end
    endtask

    task automatic test_flag_clear_coincide();
        step(1'b0, 32'd0, 1'b1, 1'b1);
        step(1'b1, 32'h7FA00001, 1'b0, 1'b0);
        step(1'b0, 32'd0, 1'b0, 1'b0);
        step(1'b0, 32'd0, 1'b1, 1'b1);
        n_cmp++;
        if (dut_flags() !== 4'b1000 || smp_out_fire !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_vs_set: flags=%b fire=%b, want 1000/1", dut_flags(), smp_out_fire);
        end
        flush();
        expdq.delete(); obsq.delete();
    endtask

    task automatic test_backpressure();
        logic [31:0] bp[4];
        logic [15:0] bo[4];
        int          idx, cyc;
        bp  = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
        bo  = '{16'h3F80, 16'h4000, 16'h4040, 16'h4080};
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            step(1'b1, bp[idx], 1'b0, 1'b0);
            if (smp_in_fire) idx++;
        end
        n_cmp++;
        if (idx != 2 || smp_in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_stall: accepts=%0d in_ready=%b, want 2/0", idx, smp_in_ready);
        end
        n_cmp++;
        if (smp_out_valid !== 1'b1 || smp_out_data !== 16'h3F80) begin
            n_fail++;
            $display("FAIL bp_hold: valid=%b data=%h, want 1/3F80", smp_out_valid, smp_out_data);
        end
        cyc = 0;
        while (obsq.size() < 4 && cyc < 20) begin
            step(idx < 4, bp[idx % 4], 1'b1, 1'b0);
            if (smp_in_fire) idx++;
            cyc++;
        end
        n_cmp++;
        if (cyc != 4) begin
            n_fail++;
            $display("FAIL bp_rate: drained in %0d cycles, want 4", cyc);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (obsq.size() <= i || obsq[i] !== {1'b0, bo[i]}) begin
                n_fail++;
                $display("FAIL bp_order[%0d]: got %h, want %h", i,
                         (obsq.size() > i) ? obsq[i] : 17'h1FFFF, bo[i]);
            end
        end
        flush();
        expdq.delete(); obsq.delete();
    endtask

    task automatic test_random();
        logic [31:0] d;
        logic [31:0] r;
        for (int c = 0; c < 500; c++) begin
            r = $urandom;
            case ($urandom_range(0, 5))
                0: d = {r[31:16], 16'h8000};
                1: d = {r[31], 8'hFF, r[22:0]};
                2: d = {r[31], 8'h00, r[22:0]};
                3: d = {r[31], 15'h7F7F, r[15:0]};
                default: d = r;
            endcase
            step($urandom_range(0, 3) != 0, d, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 15) == 0);
            n_cmp++;
            if (dut_flags() !== model_flags) begin
                n_fail++;
                $display("FAIL rnd_flags@%0d: got %b, want %b", c, dut_flags(), model_flags);
            end
        end
        flush();
        n_cmp++;
        if (expq.size() != 0 || obsq.size() != expdq.size()) begin
            n_fail++;
            $display("FAIL rnd_count: pending=%0d obs=%0d exp=%0d, want 0 and equal",
                     expq.size(), obsq.size(), expdq.size());
        end
        for (int i = 0; i < obsq.size() && i < expdq.size(); i++) begin
            n_cmp++;
            if (obsq[i] !== expdq[i]) begin
                n_fail++;
                $display("FAIL rnd_data[%0d]: got %h, want %h", i, obsq[i], expdq[i]);
            end
        end
        expdq.delete(); obsq.delete();
    endtask

    task automatic test_reset_midstream();
        step(1'b1, 32'h3F800000, 1'b0, 1'b0);
        step(1'b1, 32'h40000000, 1'b0, 1'b0);
        #2;
        nreset = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out_data !== 16'd0) begin
            n_fail++;
            $display("FAIL rst_async: valid=%b data=%h, want 0/0000", out_valid, out_data);
        end
        expq.delete(); expdq.delete(); obsq.delete();
        model_flags = 4'd0;
        @(posedge clock);
        #1;
        nreset = 1'b1;
        for (int c = 0; c < 6; c++) step(1'b0, 32'd0, 1'b1, 1'b0);
        n_cmp++;
        if (obsq.size() != 0) begin
            n_fail++;
            $display("FAIL rst_stale: %0d outputs after reset, want 0", obsq.size());
        end
        n_cmp++;
        if (dut_flags() !== 4'd0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_state: flags=%b in_ready=%b, want 0000/1", dut_flags(), in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_directed();
        test_flag_clear_coincide();
        test_backpressure();
        test_random();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fp32_to_bf16_narrow.md
Name: fp32_to_bf16_narrow

Overview:
- Narrows IEEE-754 binary32 operands to bfloat16 using round-to-nearest-even. It is the inverse of the zero-pad widening (bf16 → fp32) used in front of the fp32 datapath.
- Two-stage pipeline with valid/ready handshakes on both sides. Throughput is one conversion per cycle.
- Sits between the fp32 arithmetic units (e.g. the fp32 adder core) and bf16 consumers or storage.
- Also keeps sticky exception flags.

Parameters:
- PIPE_OUT, 1, 1 registers stage-2 output (latency 2); 0 makes stage 2 combinational from the stage-1 register (latency 1).
- CANON_NAN, 16'h7FC0, magnitude of the canonical quiet NaN; the sign is taken from the input.

Ports:
- clock  input  1  rising-edge clock
- nreset  input  1  asynchronous active-low reset
- in_data  input  32  fp32 operand
- in_valid  input  1  in_data valid
- in_ready  output  1  block can accept in_data this cycle
- out_data  output  16  bf16 result
- out_valid  output  1  out_data valid
- out_ready  input  1  consumer accepts out_data
- flag_clear  input  1  clears all sticky flags
- flag_inexact  output  1  sticky; a discarded bit was nonzero
- flag_overflow  output  1  sticky; a finite input rounded to infinity
- flag_nan  output  1  sticky; input was NaN
- flag_underflow  output  1  sticky; denormal flushed (only when BF16_FTZ_EN, else tied 0)

Behaviour:
- Reset:
  - Asynchronous, active-low.
  - All valid bits and out_valid = 0; out_data = 0; all flags = 0.
  - in_ready = 1 one cycle after reset deassertion and thereafter when empty.
  - Reset mid-stream discards all in-flight data.
- Handshake:
  - Transfer occurs when valid & ready are high in the same cycle.
  - out_data and out_valid stay stable while out_valid & !out_ready.
  - in_ready depends only on internal state and out_ready; it never depends on in_valid.
- Stage advance:
  - adv2 = !s2_valid | out_ready
  - adv1 = !s1_valid | adv2
  - in_ready = adv1
  - Full throughput with out_ready tied high. No bubbles on simultaneous accept and drain.
- Stage 1 (register on in accept), from in_data:
  - sign = bit 31, exp = [30:23], upper = [31:16], lsb = bit 16, guard = bit 15, sticky = |[14:0].
  - Classify: NaN (exp = FF, mantissa ≠ 0), Inf (exp = FF, mantissa = 0), Zero, Denormal (exp = 0, mantissa ≠ 0), Normal.
  - Compute inc = guard & (sticky | lsb).
- Stage 2 result:
  - NaN → {sign, CANON_NAN[14:0]}; set nan; no inexact.
  - Inf → upper unchanged; no flags.
  - Zero → upper unchanged.
  - Normal/Denormal → res = upper + inc (16-bit add; the mantissa carry propagates into the exponent).
    - If guard | sticky: set inexact.
    - If the input exp < FF and res[14:7] = FF: set overflow; result is signed Inf (natural from the carry).
    - Max finite 0x7F7F is produced only when inc = 0.
- Flags:
  - Updated only on the output transfer cycle (out_valid & out_ready); OR-accumulated.
  - flag_clear zeroes them next cycle. If clear and set coincide, set wins.
- Ordering: strictly FIFO; no result is dropped or duplicated under any backpressure pattern.

Optional Feature:
- Macro: BF16_FTZ_EN.
- Defined:
  - Denormal inputs → signed zero {sign, 15'b0}; set underflow and inexact.
  - Normal input with exp = 0 after rounding (impossible for normals) is not checked.
  - flag_underflow is a live sticky register.
- Undefined:
  - Denormals are rounded with the same RNE rule; the result may round up into the smallest normal 0x0080.
  - flag_underflow is constant 0.

Test Plan:
- in 0x3F800000, out_ready = 1 → out 0x3F80 exactly 2 cycles after accept (PIPE_OUT = 1); no flags.
- Ties:
  - 0x3F808000 → 0x3F80 with inexact.
  - 0x3F818000 → 0x3F82.
  - 0x3F808001 → 0x3F81.
- Overflow: 0x7F7FFFFF → 0x7F80 with overflow and inexact; 0xFF800000 → 0xFF80 with no new flags after flag_clear.
- NaN and denormal:
  - 0x7FA00001 → 0x7FC0 with nan; 0xFFC00000 → 0xFFC0.
  - 0x00008000 → 0x0000 with underflow under BF16_FTZ_EN, else 0x0000 with inexact.
- Backpressure:
  - Offer 0x3F800000, 0x40000000, 0x40400000, 0x40800000 back-to-back with out_ready = 0 for 6 cycles.
  - in_ready drops after 2 accepts and out_data holds 0x3F80.
  - After release: 0x3F80, 0x4000, 0x4040, 0x4080 in order, one per cycle.
- Reset and flag clear:
  - Assert nreset low with 2 items in flight → out_valid = 0 immediately (asynchronous); no stale output after release.
  - flag_clear in the same cycle as a NaN output transfer → flag_nan = 1.
